// File: rtl/inert_pkg.sv
// Shared constants and types for the inertial-sensor SPI responder.
package inert_pkg;

  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO      = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1    = 7'h10;
  localparam logic [6:0] ADDR_CTRL2    = 7'h11;
  localparam logic [6:0] ADDR_CTRL5    = 7'h14;
  localparam logic [6:0] ADDR_ROLL_L   = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H   = 7'h25;
  localparam logic [6:0] ADDR_YAW_L    = 7'h26;
  localparam logic [6:0] ADDR_YAW_H    = 7'h27;
  localparam logic [6:0] ADDR_AY_L     = 7'h2A;
  localparam logic [6:0] ADDR_AY_H     = 7'h2B;
  localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

  localparam int         INT_EN_BIT = 1;
  localparam int         FRAME_LEN  = 16;
  localparam logic [4:0] CNT_ADDR   = 5'd8;
  localparam logic [4:0] CNT_FRAME  = 5'(FRAME_LEN);
  localparam logic [4:0] CNT_MAX    = 5'd17;

  typedef struct packed {
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [15:0] ay;
    logic [15:0] az;
  } sample_t;

endpackage

// File: rtl/spi_resp_phy.sv
// SPI mode-0 slave front end: input sync, edge detect, bit count, rx/tx shift.
module spi_resp_phy
  import inert_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] rd_byte,
  output logic       miso,
  output logic       addr_vld,
  output logic [6:0] addr,
  output logic       is_rd,
  output logic       wr_vld,
  output logic [7:0] wr_data,
  output logic       frm_end
);

  // [0] first stage, [1] synced, [2] previous synced value for edge detect
  logic [2:0]  ss_sync_q, ss_sync_d, sclk_sync_q, sclk_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        active_q, active_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        txen_q, txen_d;
  logic        miso_q, miso_d;
  logic        addr_vld_q, addr_vld_d;
  logic [6:0]  addr_q, addr_d;
  logic        is_rd_q, is_rd_d;
  logic        wr_vld_q, wr_vld_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frm_end_q, frm_end_d;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

  always_comb begin
    ss_sync_d   = {ss_sync_q[1:0], ss_n};
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    ss_fall   =  ss_sync_q[2] & ~ss_sync_q[1];
    ss_rise   = ~ss_sync_q[2] &  ss_sync_q[1];
    sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
    sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
    mosi_s    = mosi_sync_q[1];

    active_d   = active_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    txen_d     = txen_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    wr_data_d  = wr_data_q;
    addr_vld_d = 1'b0;
    wr_vld_d   = 1'b0;
    frm_end_d  = 1'b0;
    miso_d     = txen_q & tx_q[7];

    if (ss_fall) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rx_d     = '0;
      txen_d   = 1'b0;
      addr_d   = '0;
      is_rd_d  = 1'b0;
    end else if (active_q) begin
      if (sclk_rise) begin
        rx_d = {rx_q[14:0], mosi_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_ADDR - 5'd1) begin
          addr_vld_d = 1'b1;
          addr_d     = {rx_q[5:0], mosi_s};
          is_rd_d    = rx_q[6];
        end
      end
      if (sclk_fall) begin
        if (cnt_q == CNT_ADDR && is_rd_q) begin
          tx_d   = rd_byte;
          txen_d = 1'b1;
        end else if (cnt_q > CNT_ADDR && cnt_q < CNT_FRAME) begin
          tx_d = {tx_q[6:0], 1'b0};
        end else if (cnt_q >= CNT_FRAME) begin
          txen_d = 1'b0;
        end
      end
      // Uses the _d values so a coincident SCLK edge is counted before the frame closes
      if (ss_rise) begin
        active_d  = 1'b0;
        txen_d    = 1'b0;
        frm_end_d = 1'b1;
        wr_vld_d  = ~rx_d[15] && (cnt_d == CNT_FRAME);
        wr_data_d = rx_d[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      txen_q      <= 1'b0;
      miso_q      <= 1'b0;
      addr_vld_q  <= 1'b0;
      addr_q      <= '0;
      is_rd_q     <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_data_q   <= '0;
      frm_end_q   <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      txen_q      <= txen_d;
      miso_q      <= miso_d;
      addr_vld_q  <= addr_vld_d;
      addr_q      <= addr_d;
      is_rd_q     <= is_rd_d;
      wr_vld_q    <= wr_vld_d;
      wr_data_q   <= wr_data_d;
      frm_end_q   <= frm_end_d;
    end
  end

  assign miso     = miso_q;
  assign addr_vld = addr_vld_q;
  assign addr     = addr_q;
  assign is_rd    = is_rd_q;
  assign wr_vld   = wr_vld_q;
  assign wr_data  = wr_data_q;
  assign frm_end  = frm_end_q;

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial sensor SPI responder: register file, burst lock, pending sample, INT.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smp_vld,
  input  logic [15:0] smp_roll,
  input  logic [15:0] smp_yaw,
  input  logic [15:0] smp_AY,
  input  logic [15:0] smp_AZ
);

  logic       addr_vld, is_rd, wr_vld, frm_end;
  logic [6:0] addr;
  logic [7:0] wr_data, rd_byte;

  logic [7:0] int_ctrl_q, int_ctrl_d, ctrl1_q, ctrl1_d;
  logic [7:0] ctrl2_q, ctrl2_d, ctrl5_q, ctrl5_d;
  sample_t    dat_q, dat_d, pend_q, pend_d, smp_in;
  logic       pend_vld_q, pend_vld_d;
  logic       lock_q, lock_d;
  logic       applied_q, applied_d;
  logic       int_q, int_d;
  logic       lock_set, lock_clr;

  spi_resp_phy u_phy (
    .clk     (clk),
    .rst     (rst),
    .ss_n    (SS_n),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .rd_byte (rd_byte),
    .miso    (MISO),
    .addr_vld(addr_vld),
    .addr    (addr),
    .is_rd   (is_rd),
    .wr_vld  (wr_vld),
    .wr_data (wr_data),
    .frm_end (frm_end)
  );

  always_comb begin
    case (addr)
      ADDR_INT_CTRL: rd_byte = int_ctrl_q;
      ADDR_WHO:      rd_byte = WHO_AM_I;
      ADDR_CTRL1:    rd_byte = ctrl1_q;
      ADDR_CTRL2:    rd_byte = ctrl2_q;
      ADDR_CTRL5:    rd_byte = ctrl5_q;
      ADDR_ROLL_L:   rd_byte = dat_q.roll[7:0];
      ADDR_ROLL_H:   rd_byte = dat_q.roll[15:8];
      ADDR_YAW_L:    rd_byte = dat_q.yaw[7:0];
      ADDR_YAW_H:    rd_byte = dat_q.yaw[15:8];
      ADDR_AY_L:     rd_byte = dat_q.ay[7:0];
      ADDR_AY_H:     rd_byte = dat_q.ay[15:8];
      ADDR_AZ_L:     rd_byte = dat_q.az[7:0];
      ADDR_AZ_H:     rd_byte = dat_q.az[15:8];
      default:       rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    smp_in     = '{roll: smp_roll, yaw: smp_yaw, ay: smp_AY, az: smp_AZ};
    int_ctrl_d = int_ctrl_q;
    ctrl1_d    = ctrl1_q;
    ctrl2_d    = ctrl2_q;
    ctrl5_d    = ctrl5_q;
    dat_d      = dat_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    lock_d     = lock_q;
    applied_d  = 1'b0;

    lock_set = addr_vld & is_rd & (addr == ADDR_ROLL_L);
    lock_clr = frm_end  & is_rd & (addr == ADDR_AZ_H);
    if (lock_clr) lock_d = 1'b0;
    if (lock_set) lock_d = 1'b1;

    // A fresh sample arriving as the lock drops is newer than the pending one
    if (smp_vld) begin
      if (lock_q && !lock_clr) begin
        pend_d     = smp_in;
        pend_vld_d = 1'b1;
      end else begin
        dat_d      = smp_in;
        pend_vld_d = 1'b0;
        applied_d  = 1'b1;
      end
    end else if (lock_clr && pend_vld_q) begin
      dat_d      = pend_q;
      pend_vld_d = 1'b0;
      applied_d  = 1'b1;
    end

    int_d = int_q | (applied_q & int_ctrl_q[INT_EN_BIT]);
    if (lock_set) int_d = 1'b0;

    if (frm_end && wr_vld) begin
      case (addr)
        ADDR_INT_CTRL: int_ctrl_d = wr_data;
        ADDR_CTRL1:    ctrl1_d    = wr_data;
        ADDR_CTRL2:    ctrl2_d    = wr_data;
        ADDR_CTRL5:    ctrl5_d    = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_ctrl_q <= '0;
      ctrl1_q    <= '0;
      ctrl2_q    <= '0;
      ctrl5_q    <= '0;
      dat_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      lock_q     <= 1'b0;
      applied_q  <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      int_ctrl_q <= int_ctrl_d;
      ctrl1_q    <= ctrl1_d;
      ctrl2_q    <= ctrl2_d;
      ctrl5_q    <= ctrl5_d;
      dat_q      <= dat_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      lock_q     <= lock_d;
      applied_q  <= applied_d;
      int_q      <= int_d;
    end
  end

  assign INT = int_q;

endmodule
